jesd_tx_link_ctrl: RTL and testbench

//  JESD204B TX link-layer control FSM (CGS -> ILAS -> DATA).

---
 rtl/jesd_tx_link_ctrl_if.sv | 28 ++
 rtl/jesd_tx_link_ctrl.sv | 137 +++++++++++++
 tb/tb_jesd_tx_link_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/jesd_tx_link_ctrl_if.sv
// Link-control bus between the SYNC~ decoder / frame timing side and the JESD204B TX
// link controller. master drives the timing/SYNC~ inputs, slave is the link controller.
interface jesd_tx_link_ctrl_if #(
  parameter int unsigned ERR_W = 8
) ();
  logic             i_frame_tick;
  logic             i_lmfc_edge;
  logic             i_sync_n;
  logic             i_sync_request_tx;
  logic             i_err_reporting;
  logic [1:0]       o_state;
  logic             o_send_k;
  logic [1:0]       o_ilas_mf_idx;
  logic             o_mf_end;
  logic             o_ilas_cfg_mf;
  logic             o_data_valid;
  logic [ERR_W-1:0] o_err_cnt;

  modport master (
    output i_frame_tick, i_lmfc_edge, i_sync_n, i_sync_request_tx, i_err_reporting,
    input  o_state, o_send_k, o_ilas_mf_idx, o_mf_end, o_ilas_cfg_mf, o_data_valid, o_err_cnt
  );

  modport slave (
    input  i_frame_tick, i_lmfc_edge, i_sync_n, i_sync_request_tx, i_err_reporting,
    output o_state, o_send_k, o_ilas_mf_idx, o_mf_end, o_ilas_cfg_mf, o_data_valid, o_err_cnt
  );
endinterface

// File: rtl/jesd_tx_link_ctrl.sv
// JESD204B TX link-layer control FSM (CGS -> ILAS -> DATA), all outputs registered.
// Define JESD_TX_ERR_CNT_EN to build the DATA-state error-report counter.
module jesd_tx_link_ctrl #(
  parameter int unsigned K       = 32,
  parameter int unsigned ILAS_MF = 4,
  parameter int unsigned ERR_W   = 8
) (
  input logic               clk,
  input logic               rst,
  jesd_tx_link_ctrl_if.slave bus_io
);

  localparam logic [1:0] StCgs  = 2'b00;
  localparam logic [1:0] StIlas = 2'b01;
  localparam logic [1:0] StData = 2'b10;

  localparam logic [4:0] FrameLast = 5'(K - 1);
  localparam logic [1:0] IdxLast   = 2'(ILAS_MF - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [4:0] frame_cnt_q, frame_cnt_d;
  logic       sync_seen_q, sync_seen_d;
  logic       mf_end_q, send_k_q, cfg_mf_q, data_valid_q;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (bus_io.i_lmfc_edge) begin
      frame_cnt_d = '0;
    end else if (bus_io.i_frame_tick) begin
      frame_cnt_d = (frame_cnt_q == FrameLast) ? 5'd0 : frame_cnt_q + 5'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sync_seen_d = sync_seen_q;
    case (state_q)
      StCgs: begin
        if (!bus_io.i_sync_n) begin
          sync_seen_d = 1'b0;
        end else if (!bus_io.i_sync_request_tx) begin
          sync_seen_d = 1'b1;
        end
        if (bus_io.i_lmfc_edge && sync_seen_q) begin
          state_d = StIlas;
          idx_d   = '0;
        end
      end
      StIlas: begin
        // A re-init request beats a coincident LMFC edge.
        if (bus_io.i_sync_request_tx) begin
          state_d     = StCgs;
          idx_d       = '0;
          sync_seen_d = 1'b0;
        end else if (bus_io.i_lmfc_edge) begin
          if (idx_q == IdxLast) begin
            state_d = StData;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      StData: begin
        if (bus_io.i_sync_request_tx) begin
          state_d     = StCgs;
          idx_d       = '0;
          sync_seen_d = 1'b0;
        end
      end
      default: begin
        state_d     = StCgs;
        idx_d       = '0;
        sync_seen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StCgs;
      idx_q        <= '0;
      frame_cnt_q  <= '0;
      sync_seen_q  <= 1'b0;
      mf_end_q     <= 1'b0;
      send_k_q     <= 1'b1;
      cfg_mf_q     <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_cnt_q  <= frame_cnt_d;
      sync_seen_q  <= sync_seen_d;
      mf_end_q     <= (frame_cnt_d == FrameLast);
      send_k_q     <= (state_d == StCgs);
      cfg_mf_q     <= (state_d == StIlas) && (idx_d == 2'd1);
      data_valid_q <= (state_d == StData);
    end
  end

  assign bus_io.o_state       = state_q;
  assign bus_io.o_send_k      = send_k_q;
  assign bus_io.o_ilas_mf_idx = idx_q;
  assign bus_io.o_mf_end      = mf_end_q;
  assign bus_io.o_ilas_cfg_mf = cfg_mf_q;
  assign bus_io.o_data_valid  = data_valid_q;

`ifdef JESD_TX_ERR_CNT_EN
  logic             err_q;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (bus_io.i_err_reporting && !err_q && (state_q == StData) && !(&err_cnt_q)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= bus_io.i_err_reporting;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus_io.o_err_cnt = err_cnt_q;
`else
  logic unused_err_reporting;
  assign unused_err_reporting = bus_io.i_err_reporting;
  assign bus_io.o_err_cnt     = '0;
`endif

endmodule

// File: tb/tb_jesd_tx_link_ctrl.sv
// Directed self-checking bench for jesd_tx_link_ctrl (K=32, ILAS_MF=4, ERR_W=8).
module tb_jesd_tx_link_ctrl;

`ifdef JESD_TX_ERR_CNT_EN
  localparam int unsigned ErrOne = 1;
  localparam int unsigned ErrMax = 255;
`else
  localparam int unsigned ErrOne = 0;
  localparam int unsigned ErrMax = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  jesd_tx_link_ctrl_if #(.ERR_W(8)) bus ();

  jesd_tx_link_ctrl #(
    .K      (32),
    .ILAS_MF(4),
    .ERR_W  (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_frame_tick = 1'b1;
      tick();
      bus.i_frame_tick = 1'b0;
    end
  endtask

  task automatic lmfc();
    bus.i_frame_tick = 1'b1;
    bus.i_lmfc_edge  = 1'b1;
    tick();
    bus.i_frame_tick = 1'b0;
    bus.i_lmfc_edge  = 1'b0;
  endtask

  task automatic err_edges(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_err_reporting = 1'b1;
      tick();
      bus.i_err_reporting = 1'b0;
      tick();
    end
  endtask

  initial begin
    bus.i_frame_tick      = 1'b0;
    bus.i_lmfc_edge       = 1'b0;
    bus.i_sync_n          = 1'b0;
    bus.i_sync_request_tx = 1'b0;
    bus.i_err_reporting   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_state", 32'(bus.o_state), 32'd0);
    chk("rst_send_k", 32'(bus.o_send_k), 32'd1);
    chk("rst_err_cnt", 32'(bus.o_err_cnt), 32'd0);
    chk("rst_idx", 32'(bus.o_ilas_mf_idx), 32'd0);
    chk("rst_dv", 32'(bus.o_data_valid), 32'd0);
    chk("rst_mf_end", 32'(bus.o_mf_end), 32'd0);

    // Frame counter wrap and LMFC realignment while SYNC~ still asserted
    frames(30);
    chk("mf_end_f30", 32'(bus.o_mf_end), 32'd0);
    frames(1);
    chk("mf_end_f31", 32'(bus.o_mf_end), 32'd1);
    frames(1);
    chk("mf_end_wrap", 32'(bus.o_mf_end), 32'd0);
    frames(19);
    lmfc();
    chk("cgs_hold_sync_low", 32'(bus.o_state), 32'd0);
    frames(30);
    chk("lmfc_align_f30", 32'(bus.o_mf_end), 32'd0);
    frames(1);
    chk("lmfc_align_f31", 32'(bus.o_mf_end), 32'd1);

    bus.i_sync_request_tx = 1'b1;
    tick();
    chk("cgs_req_ignored", 32'(bus.o_state), 32'd0);
    bus.i_sync_request_tx = 1'b0;

    // CGS -> ILAS -> DATA
    bus.i_sync_n = 1'b1;
    tick();
    lmfc();
    chk("ilas_state", 32'(bus.o_state), 32'd1);
    chk("ilas_idx0", 32'(bus.o_ilas_mf_idx), 32'd0);
    chk("ilas_send_k", 32'(bus.o_send_k), 32'd0);
    chk("ilas_cfg0", 32'(bus.o_ilas_cfg_mf), 32'd0);
    lmfc();
    chk("ilas_idx1", 32'(bus.o_ilas_mf_idx), 32'd1);
    chk("ilas_cfg1", 32'(bus.o_ilas_cfg_mf), 32'd1);
    lmfc();
    chk("ilas_idx2", 32'(bus.o_ilas_mf_idx), 32'd2);
    chk("ilas_cfg2", 32'(bus.o_ilas_cfg_mf), 32'd0);
    lmfc();
    chk("ilas_idx3", 32'(bus.o_ilas_mf_idx), 32'd3);
    chk("ilas_state3", 32'(bus.o_state), 32'd1);
    lmfc();
    chk("data_state", 32'(bus.o_state), 32'd2);
    chk("data_dv", 32'(bus.o_data_valid), 32'd1);
    chk("data_idx_held", 32'(bus.o_ilas_mf_idx), 32'd3);
    chk("data_send_k", 32'(bus.o_send_k), 32'd0);

    // Error counting: a held level is one edge, then saturation
    bus.i_err_reporting = 1'b1;
    tick();
    tick();
    tick();
    bus.i_err_reporting = 1'b0;
    tick();
    chk("err_level_once", 32'(bus.o_err_cnt), ErrOne);
    err_edges(299);
    chk("err_saturate", 32'(bus.o_err_cnt), ErrMax);

    // Re-init request coincident with LMFC edge
    bus.i_sync_request_tx = 1'b1;
    lmfc();
    bus.i_sync_request_tx = 1'b0;
    chk("reinit_state", 32'(bus.o_state), 32'd0);
    chk("reinit_send_k", 32'(bus.o_send_k), 32'd1);
    chk("reinit_dv", 32'(bus.o_data_valid), 32'd0);
    chk("reinit_idx", 32'(bus.o_ilas_mf_idx), 32'd0);
    chk("reinit_err_kept", 32'(bus.o_err_cnt), ErrMax);

    // Reset counter, then confirm CGS edges are not counted
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_err_clear", 32'(bus.o_err_cnt), 32'd0);
    err_edges(3);
    chk("cgs_err_ignored", 32'(bus.o_err_cnt), 32'd0);

    // ILAS re-init request, then async reset in ILAS idx 2
    tick();
    lmfc();
    chk("ilas2_state", 32'(bus.o_state), 32'd1);
    bus.i_sync_request_tx = 1'b1;
    tick();
    bus.i_sync_request_tx = 1'b0;
    chk("ilas_req_state", 32'(bus.o_state), 32'd0);
    chk("ilas_req_send_k", 32'(bus.o_send_k), 32'd1);
    tick();
    lmfc();
    lmfc();
    lmfc();
    chk("pre_rst_idx", 32'(bus.o_ilas_mf_idx), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(bus.o_state), 32'd0);
    chk("async_rst_idx", 32'(bus.o_ilas_mf_idx), 32'd0);
    chk("async_rst_send_k", 32'(bus.o_send_k), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
